// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and the parity helper used by the
// runtime-configurable UART.
package uart_pkg;

  localparam int SB_TICK      = 16;
  localparam int START_SAMPLE = 7;
  localparam int MAX_DBIT     = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DBIT-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Programmable oversampling tick generator: one tick every i_div+1 clocks,
// tick permanently high when i_div is zero.
module baud_gen #(
  parameter int DVSR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] i_div,
  output logic              o_tick
);

  logic [DVSR_W-1:0] r_cnt;
  logic              w_wrap;

  // >= keeps the period short if the divisor is lowered while counting.
  assign w_wrap = (r_cnt >= i_div);
  assign o_tick = w_wrap;

  // Free-running divisor counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DVSR_W'(1);
    end
  end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO with show-ahead head output; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_empty,
  output logic              o_full,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wp;
  logic [ADDR_W:0]   r_rp;
  logic              w_empty;
  logic              w_full;
  logic              w_do_rd;
  logic              w_do_wr;

  // Extra pointer bit distinguishes full from empty.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[ADDR_W] != r_rp[ADDR_W]) &&
                   (r_wp[ADDR_W-1:0] == r_rp[ADDR_W-1:0]);
  assign w_do_rd = i_rd && !w_empty;
  assign w_do_wr = i_wr && (!w_full || w_do_rd);

  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_rdata = r_mem[r_rp[ADDR_W-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wp[ADDR_W-1:0]] <= i_wdata;
        r_wp                    <= r_wp + (ADDR_W+1)'(1);
      end
      if (w_do_rd) begin
        r_rp <= r_rp + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: TX/RX frame engines with FIFOs, a shared baud
// tick, per-frame parity/stop configuration and sticky RX error flags.
module uart_cfg
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int DVSR_W = 16,
  parameter int FIFO_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] cfg_div,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  input  logic              rx,
  output logic              tx,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  output logic              tx_full,
  output logic              tx_busy,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              err_frame,
  output logic              err_parity,
  output logic              err_overrun,
  input  logic              clr_err
);

  logic                w_tick;
  logic                w_tx_empty;
  logic                w_tx_full;
  logic [DBIT-1:0]     w_tx_head;
  logic                w_tx_pop;
  logic                w_tx_last_stop;
  logic [MAX_DBIT-1:0] w_tx_head_ext;
  logic                w_rx_empty;
  logic                w_rx_full;
  logic                w_rx;
  logic                w_rx_last_stop;
  logic [MAX_DBIT-1:0] w_rx_shift_ext;

  tx_state_t           r_tx_state;
  logic [4:0]          r_tx_s;
  logic [2:0]          r_tx_n;
  logic [DBIT-1:0]     r_tx_shift;
  logic                r_tx_par_en;
  logic                r_tx_stop2;
  logic                r_tx_pbit;
  logic                r_tx;
  logic                r_tx_busy;

  rx_state_t           r_rx_state;
  logic [1:0]          r_rx_sync;
  logic [4:0]          r_rx_s;
  logic [2:0]          r_rx_n;
  logic [DBIT-1:0]     r_rx_shift;
  logic                r_rx_par_en;
  logic                r_rx_par_odd;
  logic                r_rx_stop2;
  logic                r_rx_perr;
  logic                r_rx_ferr;
  logic                r_rx_done;
  logic [DBIT-1:0]     r_rx_byte;
  logic                r_err_frame;
  logic                r_err_parity;
  logic                r_err_overrun;

  baud_gen #(.DVSR_W(DVSR_W)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .i_div  (cfg_div),
    .o_tick (w_tick)
  );

  fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_rd    (w_tx_pop),
    .i_wr    (wr_uart),
    .i_wdata (w_data),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full),
    .o_rdata (w_tx_head)
  );

  fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_rd    (rd_uart),
    .i_wr    (r_rx_done),
    .i_wdata (r_rx_byte),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full),
    .o_rdata (r_data)
  );

  // Zero-extend data words for the shared parity helper.
  always_comb begin
    w_tx_head_ext            = '0;
    w_tx_head_ext[DBIT-1:0]  = w_tx_head;
    w_rx_shift_ext           = '0;
    w_rx_shift_ext[DBIT-1:0] = r_rx_shift;
  end

  assign w_tx_last_stop = r_tx_stop2 ? (r_tx_s == 5'(2*SB_TICK-1))
                                     : (r_tx_s == 5'(SB_TICK-1));
  assign w_tx_pop       = (r_tx_state == TX_STOP) && w_tick && w_tx_last_stop;
  assign w_rx_last_stop = r_rx_stop2 ? (r_rx_s == 5'(2*SB_TICK-1))
                                     : (r_rx_s == 5'(SB_TICK-1));
  assign w_rx           = r_rx_sync[1];

  // TX frame engine; tx and tx_busy are registered from the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state  <= TX_IDLE;
      r_tx_s      <= 5'd0;
      r_tx_n      <= 3'd0;
      r_tx_shift  <= '0;
      r_tx_par_en <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_tx_pbit   <= 1'b0;
      r_tx        <= 1'b1;
      r_tx_busy   <= 1'b0;
    end else begin
      r_tx_busy <= (r_tx_state != TX_IDLE) || !w_tx_empty;
      case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (!w_tx_empty) begin
            r_tx_state  <= TX_START;
            r_tx_s      <= 5'd0;
            r_tx_shift  <= w_tx_head;
            r_tx_par_en <= cfg_par_en;
            r_tx_stop2  <= cfg_stop2;
            r_tx_pbit   <= parity_bit(w_tx_head_ext, cfg_par_odd);
          end
        end
        TX_START: begin
          r_tx <= 1'b0;
          if (w_tick) begin
            if (r_tx_s == 5'(SB_TICK-1)) begin
              r_tx_s     <= 5'd0;
              r_tx_n     <= 3'd0;
              r_tx_state <= TX_DATA;
            end else begin
              r_tx_s <= r_tx_s + 5'd1;
            end
          end
        end
        TX_DATA: begin
          r_tx <= r_tx_shift[0];
          if (w_tick) begin
            if (r_tx_s == 5'(SB_TICK-1)) begin
              r_tx_s     <= 5'd0;
              r_tx_shift <= {1'b0, r_tx_shift[DBIT-1:1]};
              if (r_tx_n == 3'(DBIT-1)) begin
                r_tx_state <= r_tx_par_en ? TX_PARITY : TX_STOP;
              end else begin
                r_tx_n <= r_tx_n + 3'd1;
              end
            end else begin
              r_tx_s <= r_tx_s + 5'd1;
            end
          end
        end
        TX_PARITY: begin
          r_tx <= r_tx_pbit;
          if (w_tick) begin
            if (r_tx_s == 5'(SB_TICK-1)) begin
              r_tx_s     <= 5'd0;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_s <= r_tx_s + 5'd1;
            end
          end
        end
        TX_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            if (w_tx_last_stop) begin
              r_tx_s     <= 5'd0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_s <= r_tx_s + 5'd1;
            end
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser on the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync <= 2'b11;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rx};
    end
  end

  // RX frame engine; r_rx_done pushes the assembled byte one clock later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_s       <= 5'd0;
      r_rx_n       <= 3'd0;
      r_rx_shift   <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_stop2   <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_done    <= 1'b0;
      r_rx_byte    <= '0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_rx_state   <= RX_START;
            r_rx_s       <= 5'd0;
            r_rx_par_en  <= cfg_par_en;
            r_rx_par_odd <= cfg_par_odd;
            r_rx_stop2   <= cfg_stop2;
            r_rx_perr    <= 1'b0;
            r_rx_ferr    <= 1'b0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_s == 5'(START_SAMPLE)) begin
              r_rx_s     <= 5'd0;
              r_rx_n     <= 3'd0;
              r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_s <= r_rx_s + 5'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_s == 5'(SB_TICK-1)) begin
              r_rx_s     <= 5'd0;
              r_rx_shift <= {w_rx, r_rx_shift[DBIT-1:1]};
              if (r_rx_n == 3'(DBIT-1)) begin
                r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
              end else begin
                r_rx_n <= r_rx_n + 3'd1;
              end
            end else begin
              r_rx_s <= r_rx_s + 5'd1;
            end
          end
        end
        RX_PARITY: begin
          if (w_tick) begin
            if (r_rx_s == 5'(SB_TICK-1)) begin
              r_rx_s     <= 5'd0;
              r_rx_perr  <= (w_rx != parity_bit(w_rx_shift_ext, r_rx_par_odd));
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_s <= r_rx_s + 5'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            // Sample points: end of the first stop bit and, if enabled, the second.
            if ((r_rx_s == 5'(SB_TICK-1)) || (r_rx_s == 5'(2*SB_TICK-1))) begin
              r_rx_ferr <= r_rx_ferr | !w_rx;
            end
            if (w_rx_last_stop) begin
              r_rx_s     <= 5'd0;
              r_rx_state <= RX_IDLE;
              r_rx_done  <= 1'b1;
              r_rx_byte  <= r_rx_shift;
            end else begin
              r_rx_s <= r_rx_s + 5'd1;
            end
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_frame   <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_frame   <= (r_err_frame   & ~clr_err) | (r_rx_done & r_rx_ferr);
      r_err_parity  <= (r_err_parity  & ~clr_err) | (r_rx_done & r_rx_perr);
      r_err_overrun <= (r_err_overrun & ~clr_err) |
                       (r_rx_done & w_rx_full & ~rd_uart);
    end
  end

  assign tx          = r_tx;
  assign tx_busy     = r_tx_busy;
  assign tx_full     = w_tx_full;
  assign rx_empty    = w_rx_empty;
  assign rx_full     = w_rx_full;
  assign err_frame   = r_err_frame;
  assign err_parity  = r_err_parity;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: loopback, parity/two-stop framing, RX error
// injection, overrun, glitch rejection, TX FIFO full and mid-frame reset.
module tb_uart_cfg;

  localparam int BIT = 64;  // clocks per bit with cfg_div = 3

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfg_div;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_stop2;
  logic        rx;
  logic        tx;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        tx_full;
  logic        tx_busy;
  logic        rd_uart;
  logic [7:0]  r_data;
  logic        rx_empty;
  logic        rx_full;
  logic        err_frame;
  logic        err_parity;
  logic        err_overrun;
  logic        clr_err;
  logic        loop_en;
  logic        rx_drv;

  int checks = 0;
  int errors = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_cfg #(.DBIT(8), .DVSR_W(16), .FIFO_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_div     (cfg_div),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .rx          (rx),
    .tx          (tx),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy),
    .rd_uart     (rd_uart),
    .r_data      (r_data),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .err_frame   (err_frame),
    .err_parity  (err_parity),
    .err_overrun (err_overrun),
    .clr_err     (clr_err)
  );

  // Advance n clocks; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic use_par,
                         input logic pbit, input int stop_low);
    rx_drv = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      cycles(BIT);
    end
    if (use_par) begin
      rx_drv = pbit;
      cycles(BIT);
    end
    if (stop_low > 0) begin
      rx_drv = 1'b0;
      cycles(stop_low);
      rx_drv = 1'b1;
      cycles(BIT - stop_low);
    end else begin
      rx_drv = 1'b1;
      cycles(BIT);
    end
    cycles(BIT);
  endtask

  task automatic wait_rx_data();
    for (int n = 0; n < 200 && rx_empty !== 1'b0; n++) cycles(1);
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    cycles(1);
    rd_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_div = 16'd3; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    cfg_stop2 = 1'b0; wr_uart = 1'b0; w_data = 8'h00; rd_uart = 1'b0;
    clr_err = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_rx_full: got %b expected 0", rx_full); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_r_data: got %h expected 00", r_data); end
    checks++; if ({err_frame, err_parity, err_overrun} !== 3'b000) begin errors++;
      $display("FAIL reset_errs: got %b expected 000", {err_frame, err_parity, err_overrun}); end
  endtask

  task automatic test_loopback_8n1();
    int rise_t, fall_t, end_t;
    logic prev;
    loop_en = 1'b1;
    wr_uart = 1'b1; w_data = 8'hA5;
    cycles(1);
    wr_uart = 1'b0;
    cycles(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL lb_tx_1clk: got %b expected 1", tx); end
    cycles(1);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL lb_tx_2clk: got %b expected 0", tx); end
    rise_t = -1; fall_t = -1; end_t = -1; prev = 1'b0;
    for (int c = 1; c < 2000 && end_t < 0; c++) begin
      cycles(1);
      if (rise_t < 0 && tx === 1'b1 && prev === 1'b0) rise_t = c;
      else if (rise_t >= 0 && fall_t < 0 && tx === 1'b0) fall_t = c;
      if (tx_busy === 1'b0) end_t = c;
      prev = tx;
    end
    checks++; if (fall_t - rise_t !== BIT) begin errors++;
      $display("FAIL lb_bit_time: got %0d expected %0d", fall_t - rise_t, BIT); end
    // start-bit length depends on baud phase by up to div clocks
    checks++; if (end_t < 637 || end_t > 640) begin errors++;
      $display("FAIL lb_frame_len: got %0d expected 637..640", end_t); end
    wait_rx_data();
    checks++; if (r_data !== 8'hA5 || rx_empty !== 1'b0) begin errors++;
      $display("FAIL lb_r_data: got %h (empty %b) expected a5", r_data, rx_empty); end
    checks++; if ({err_frame, err_parity, err_overrun} !== 3'b000) begin errors++;
      $display("FAIL lb_errs: got %b expected 000", {err_frame, err_parity, err_overrun}); end
    pop_rx();
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL lb_pop: got %b expected 1", rx_empty); end
  endtask

  task automatic test_parity_stop2();
    logic [11:0] expb;
    int rise_t, end_t, k, n;
    expb = 12'b1100_0000_0110;  // start, 0x03 LSB first, even parity 0, two stops
    cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b1;
    wr_uart = 1'b1; w_data = 8'h03;
    cycles(1);
    wr_uart = 1'b0;
    for (n = 0; n < 10 && tx !== 1'b0; n++) cycles(1);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL ps_start: got %b expected 0", tx); end
    rise_t = -1; end_t = -1;
    for (int c = 1; c < 1200 && end_t < 0; c++) begin
      cycles(1);
      if (c >= 32 && (c - 32) % BIT == 0 && (c - 32) / BIT < 12) begin
        k = (c - 32) / BIT;
        checks++; if (tx !== expb[k]) begin errors++;
          $display("FAIL ps_bit%0d: got %b expected %b", k, tx, expb[k]); end
      end
      if (c > 32 + BIT * 9 && rise_t < 0 && tx === 1'b1) rise_t = c;
      if (tx_busy === 1'b0) end_t = c;
    end
    checks++; if (end_t - rise_t !== 2 * BIT) begin errors++;
      $display("FAIL ps_stop_len: got %0d expected %0d", end_t - rise_t, 2 * BIT); end
    wait_rx_data();
    checks++; if (r_data !== 8'h03 || err_parity !== 1'b0 || err_frame !== 1'b0) begin errors++;
      $display("FAIL ps_rx: got %h perr %b ferr %b expected 03 0 0", r_data, err_parity, err_frame); end
    pop_rx();
    loop_en = 1'b0; cfg_stop2 = 1'b0;
  endtask

  task automatic test_error_inject();
    cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
    send_rx(8'h55, 1'b1, 1'b1, 0);
    wait_rx_data();
    checks++; if (err_parity !== 1'b1) begin errors++; $display("FAIL ei_parity: got %b expected 1", err_parity); end
    checks++; if (r_data !== 8'h55 || rx_empty !== 1'b0) begin errors++;
      $display("FAIL ei_par_data: got %h (empty %b) expected 55", r_data, rx_empty); end
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL ei_no_frame: got %b expected 0", err_frame); end
    pop_rx();
    cfg_par_en = 1'b0;
    send_rx(8'h3C, 1'b0, 1'b0, 48);
    wait_rx_data();
    checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL ei_frame: got %b expected 1", err_frame); end
    checks++; if (r_data !== 8'h3C) begin errors++; $display("FAIL ei_frame_data: got %h expected 3c", r_data); end
    pop_rx();
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ei_single_push: got %b expected 1", rx_empty); end
    pulse_clr();
    checks++; if ({err_frame, err_parity, err_overrun} !== 3'b000) begin errors++;
      $display("FAIL ei_clr: got %b expected 000", {err_frame, err_parity, err_overrun}); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 0);
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ov_full: got %b expected 1", rx_full); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ov_flag: got %b expected 1", err_overrun); end
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL ov_no_frame: got %b expected 0", err_frame); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_data !== 8'h10 + 8'(i)) begin errors++;
        $display("FAIL ov_read%0d: got %h expected %h", i, r_data, 8'h10 + 8'(i)); end
      pop_rx();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ov_drained: got %b expected 1", rx_empty); end
    pop_rx();
    checks++; if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin errors++;
      $display("FAIL ov_rd_empty: got empty %b full %b expected 1 0", rx_empty, rx_full); end
    pulse_clr();
  endtask

  task automatic test_glitch();
    rx_drv = 1'b0;
    cycles(12);
    rx_drv = 1'b1;
    cycles(200);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL gl_no_push: got %b expected 1", rx_empty); end
    checks++; if ({err_frame, err_parity, err_overrun} !== 3'b000) begin errors++;
      $display("FAIL gl_errs: got %b expected 000", {err_frame, err_parity, err_overrun}); end
  endtask

  task automatic test_tx_full_reset();
    for (int i = 0; i < 5; i++) begin
      wr_uart = 1'b1; w_data = 8'h60 + 8'(i);
      cycles(1);
    end
    wr_uart = 1'b0;
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL tf_full: got %b expected 1", tx_full); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tf_busy: got %b expected 1", tx_busy); end
    cycles(100);
    reset = 1'b1;
    cycles(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rs_tx: got %b expected 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rs_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_full !== 1'b0 || rx_empty !== 1'b1) begin errors++;
      $display("FAIL rs_fifos: got tx_full %b rx_empty %b expected 0 1", tx_full, rx_empty); end
    reset = 1'b0;
    cycles(200);
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++;
      $display("FAIL rs_quiet: got tx %b busy %b expected 1 0", tx, tx_busy); end
  endtask

  initial begin
    test_reset();
    test_loopback_8n1();
    test_parity_stop2();
    test_error_inject();
    test_overrun();
    test_glitch();
    test_tx_full_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
